// File: rtl/usb_boot_pkg.sv
// Shared types and default 48 MHz timing constants for the USB bootloader sequencer.
package usb_boot_pkg;

    // Sequencer states; the encoding is exported on state_dbg.
    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_HOLD_RST  = 3'd1,
        ST_ATTACH    = 3'd2,
        ST_ACTIVE    = 3'd3,
        ST_DRAIN     = 3'd4,
        ST_BOOT      = 3'd5
    } state_e;

    // Default cycle counts at 48 MHz.
    localparam int unsigned DEF_RESET_CYCLES    = 32'd4800;       // 100 us
    localparam int unsigned DEF_HOST_TIMEOUT    = 32'd960000000;  // 20 s
    localparam int unsigned DEF_SOF_LOSS_CYCLES = 32'd144000;     // 3 ms
    localparam int unsigned DEF_DRAIN_CYCLES    = 32'd48000;      // 1 ms
    localparam logic [1:0]  DEF_BOOT_IMAGE      = 2'b01;

endpackage : usb_boot_pkg

// File: rtl/usb_boot_sequencer.sv
// USB bootloader bring-up / hand-off sequencer: waits for PLL lock, holds the
// USB engine in reset, enables the D+ pull-up, tracks host SOFs and fires
// SB_WARMBOOT on host timeout or on an explicit boot request.
module usb_boot_sequencer
    import usb_boot_pkg::*;
#(
    parameter int unsigned RESET_CYCLES    = DEF_RESET_CYCLES,
    parameter int unsigned HOST_TIMEOUT    = DEF_HOST_TIMEOUT,
    parameter int unsigned SOF_LOSS_CYCLES = DEF_SOF_LOSS_CYCLES,
    parameter int unsigned DRAIN_CYCLES    = DEF_DRAIN_CYCLES,
    parameter logic [1:0]  BOOT_IMAGE      = DEF_BOOT_IMAGE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_lock,
    input  logic       sof_valid,
    input  logic       boot_req,
    output logic       usb_reset,
    output logic       usb_pu,
    output logic       host_present,
    output logic       warmboot_boot,
    output logic [1:0] warmboot_s,
    output logic [2:0] state_dbg
);

    // Terminal timer values; each state leaves when its timer reaches these.
    localparam logic [31:0] RESET_LAST = 32'(RESET_CYCLES - 1);
    localparam logic [31:0] HOST_LAST  = 32'(HOST_TIMEOUT - 1);
    localparam logic [31:0] LOSS_LAST  = 32'(SOF_LOSS_CYCLES - 1);
    localparam logic [31:0] DRAIN_LAST = 32'(DRAIN_CYCLES - 1);

    state_e      state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic        lock_meta_q, lock_s_q;
    logic        usb_reset_q, usb_reset_d;
    logic        usb_pu_q, usb_pu_d;
    logic        host_present_q, host_present_d;
    logic        warmboot_boot_q, warmboot_boot_d;

    // Next-state and timer: lock loss > boot_req > sof_valid > timeout.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        timer_d = timer_q + 32'd1;
        unique case (state_q)
            ST_WAIT_LOCK: begin
                timer_d = '0;
                if (lock_s_q) state_d = ST_HOLD_RST;
            end
            ST_HOLD_RST: begin
                if (timer_q == RESET_LAST) begin
                    state_d = ST_ATTACH;
                    timer_d = '0;
                end
            end
            ST_ATTACH: begin
                if (boot_req) begin
                    state_d = ST_DRAIN;
                    timer_d = '0;
                end else if (sof_valid) begin
                    state_d = ST_ACTIVE;
                    timer_d = '0;
                end else if (timer_q == HOST_LAST) begin
                    state_d = ST_BOOT;
                    timer_d = '0;
                end
            end
            ST_ACTIVE: begin
                if (boot_req) begin
                    state_d = ST_DRAIN;
                    timer_d = '0;
                end else if (sof_valid) begin
                    timer_d = '0;
                end else if (timer_q == LOSS_LAST) begin
                    // Host went quiet: re-arm the host timeout without resetting the engine.
                    state_d = ST_ATTACH;
                    timer_d = '0;
                end
            end
            ST_DRAIN: begin
                // Lets the pending IN ACK finish before the FPGA reconfigures.
                if (timer_q == DRAIN_LAST) begin
                    state_d = ST_BOOT;
                    timer_d = '0;
                end
            end
            ST_BOOT: begin
                timer_d = '0;
            end
            default: begin
                state_d = ST_WAIT_LOCK;
                timer_d = '0;
            end
        endcase
        // Losing lock restarts bring-up from anywhere except the terminal BOOT state.
        if (!lock_s_q && (state_q != ST_BOOT)) begin
            state_d = ST_WAIT_LOCK;
            timer_d = '0;
        end
    end

    // Output decode of the next state so the registered outputs line up with state_q.
    always_comb begin
        usb_reset_d     = (state_d == ST_WAIT_LOCK) || (state_d == ST_HOLD_RST) || (state_d == ST_BOOT);
        usb_pu_d        = (state_d == ST_ATTACH) || (state_d == ST_ACTIVE) || (state_d == ST_DRAIN);
        host_present_d  = (state_d == ST_ACTIVE);
        warmboot_boot_d = (state_d == ST_BOOT);
    end

    // State, timer, lock synchronizer and registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            state_q         <= ST_WAIT_LOCK;
            timer_q         <= '0;
            lock_meta_q     <= 1'b0;
            lock_s_q        <= 1'b0;
            usb_reset_q     <= 1'b1;
            usb_pu_q        <= 1'b0;
            host_present_q  <= 1'b0;
            warmboot_boot_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            timer_q         <= timer_d;
            lock_meta_q     <= pll_lock;
            lock_s_q        <= lock_meta_q;
            usb_reset_q     <= usb_reset_d;
            usb_pu_q        <= usb_pu_d;
            host_present_q  <= host_present_d;
            warmboot_boot_q <= warmboot_boot_d;
        end
    end

    assign usb_reset     = usb_reset_q;
    assign usb_pu        = usb_pu_q;
    assign host_present  = host_present_q;
    assign warmboot_boot = warmboot_boot_q;
    assign warmboot_s    = BOOT_IMAGE;
    assign state_dbg     = state_q;

endmodule : usb_boot_sequencer
